// File: rtl/beat_sequencer.sv
// beat_sequencer: chart-driven beat/note sequencer that tallies detector hits and misses per beat
// Ports: clk, rst (sync, active-high); start/abort control; chart latched on accepted start;
//        hit from the detector; tick_out beat pulse, should_hit note window, beat_idx,
//        playing/done status, hit_cnt/miss_cnt saturating tallies.
module beat_sequencer #(
   parameter int TICK_DIV  = 1_000_000,
   parameter int CNT_W     = 20,
   parameter int WINDOW    = 250_000,
   parameter int CHART_LEN = 32,
   parameter int IDX_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CHART_LEN-1:0] chart,
   input  logic                 hit,
   output logic                 tick_out,
   output logic                 should_hit,
   output logic [IDX_W-1:0]     beat_idx,
   output logic                 playing,
   output logic                 done,
   output logic [7:0]           hit_cnt,
   output logic [7:0]           miss_cnt
);
   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
   state_t state, state_d;
   logic [CNT_W-1:0] div_cnt;
   logic [CHART_LEN-1:0] chart_q, chart_sh;
   logic note, beat_end, last_beat;
   assign chart_sh  = chart_q >> beat_idx;
   assign note      = chart_sh[0];
   assign beat_end  = div_cnt == CNT_W'(TICK_DIV - 1);
   assign last_beat = beat_idx == IDX_W'(CHART_LEN - 1);
   always_comb begin
      state_d = (state == PLAY) ? (abort ? IDLE : (beat_end && last_beat) ? DONE : PLAY)
                                : (start ? PLAY : state);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         beat_idx <= '0;
         chart_q  <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         state <= state_d;
         if (state != PLAY && start) begin
            chart_q  <= chart;
            div_cnt  <= '0;
            beat_idx <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
         end else if (state == PLAY && !abort) begin
            div_cnt <= beat_end ? '0 : div_cnt + 1'b1;
            if (beat_end) begin
               if (note && hit)  hit_cnt  <= hit_cnt + {7'd0, hit_cnt != 8'hFF};
               if (note && !hit) miss_cnt <= miss_cnt + {7'd0, miss_cnt != 8'hFF};
               if (!last_beat)   beat_idx <= beat_idx + 1'b1;
            end
         end
      end
   end
   // div_cnt restarts at 0 on every beat entry, so the beat pulse is a pure decode
   assign tick_out   = state == PLAY && div_cnt == '0;
   assign should_hit = state == PLAY && note && ({1'b0, div_cnt} < (CNT_W + 1)'(WINDOW));
   assign playing    = state == PLAY;
   assign done       = state == DONE;
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed table-driven checks of beat_sequencer plus a saturation instance
module tb_beat_sequencer;
   logic clk = 0, rst = 1, start = 0, abort = 0, hit = 0;
   logic [3:0] chart = '0;
   logic tick_out, should_hit, playing, done;
   logic [1:0] beat_idx;
   logic [7:0] hit_cnt, miss_cnt;
   logic s_start = 0;
   logic [299:0] s_chart = '1;
   logic s_tick, s_sh, s_play, s_done;
   logic [8:0] s_idx;
   logic [7:0] s_hc, s_mc;
   int total = 0, bad = 0, cyc = 0;

   beat_sequencer #(.TICK_DIV(8), .CNT_W(3), .WINDOW(3), .CHART_LEN(4), .IDX_W(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .chart(chart), .hit(hit),
      .tick_out(tick_out), .should_hit(should_hit), .beat_idx(beat_idx), .playing(playing),
      .done(done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   beat_sequencer #(.TICK_DIV(2), .CNT_W(1), .WINDOW(1), .CHART_LEN(300), .IDX_W(9)) u_sat (
      .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .chart(s_chart), .hit(1'b1),
      .tick_out(s_tick), .should_hit(s_sh), .beat_idx(s_idx), .playing(s_play),
      .done(s_done), .hit_cnt(s_hc), .miss_cnt(s_mc));

   always #5 clk = ~clk;

   typedef struct {
      bit go; logic [3:0] chart; int cyc; logic hit;
      logic tick, sh; logic [1:0] idx; logic play, done; logic [7:0] hc, mc;
   } row_t;
   row_t tbl[$];

   function automatic row_t r(bit go, logic [3:0] ch, int c, logic h, logic t, logic sh,
                              logic [1:0] i, logic p, logic d, logic [7:0] hc, logic [7:0] mc);
      row_t x;
      x.go = go; x.chart = ch; x.cyc = c; x.hit = h; x.tick = t; x.sh = sh;
      x.idx = i; x.play = p; x.done = d; x.hc = hc; x.mc = mc;
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(string n, int got, int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", n, got, exp);
      end
   endtask

   task automatic chk_row(string tag, row_t x);
      chk($sformatf("%s c%0d tick", tag, cyc), tick_out, x.tick);
      chk($sformatf("%s c%0d should_hit", tag, cyc), should_hit, x.sh);
      chk($sformatf("%s c%0d beat_idx", tag, cyc), beat_idx, x.idx);
      chk($sformatf("%s c%0d playing", tag, cyc), playing, x.play);
      chk($sformatf("%s c%0d done", tag, cyc), done, x.done);
      chk($sformatf("%s c%0d hit_cnt", tag, cyc), hit_cnt, x.hc);
      chk($sformatf("%s c%0d miss_cnt", tag, cyc), miss_cnt, x.mc);
   endtask

   task automatic run_rows(string tag, int lo, int hi);
      for (int i = lo; i <= hi; i++) begin
         hit = tbl[i].hit;
         if (tbl[i].go) begin
            chart = tbl[i].chart;
            start = 1;
            step();
            start = 0;
            cyc = 1;
         end else begin
            while (cyc < tbl[i].cyc) step();
         end
         chk_row(tag, tbl[i]);
      end
   endtask

   initial begin
      int ticks, plays;
      row_t zero;
      zero = r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // nominal song: chart 0101, hit held high
      tbl.push_back(r(1, 4'b0101,  1, 1, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(r(0, 4'b0101,  3, 1, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(r(0, 4'b0101,  4, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(r(0, 4'b0101,  8, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(r(0, 4'b0101,  9, 1, 1, 0, 1, 1, 0, 1, 0));
      tbl.push_back(r(0, 4'b0101, 17, 1, 1, 1, 2, 1, 0, 1, 0));
      tbl.push_back(r(0, 4'b0101, 19, 1, 0, 1, 2, 1, 0, 1, 0));
      tbl.push_back(r(0, 4'b0101, 20, 1, 0, 0, 2, 1, 0, 1, 0));
      tbl.push_back(r(0, 4'b0101, 25, 1, 1, 0, 3, 1, 0, 2, 0));
      tbl.push_back(r(0, 4'b0101, 32, 1, 0, 0, 3, 1, 0, 2, 0));
      tbl.push_back(r(0, 4'b0101, 33, 1, 0, 0, 3, 0, 1, 2, 0));
      tbl.push_back(r(0, 4'b0101, 34, 1, 0, 0, 3, 0, 1, 2, 0));
      // miss/empty beats: started from DONE, hit only during beat 1
      tbl.push_back(r(1, 4'b1011,  1, 0, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(r(0, 4'b1011,  9, 0, 1, 1, 1, 1, 0, 0, 1));
      tbl.push_back(r(0, 4'b1011, 17, 1, 1, 0, 2, 1, 0, 1, 1));
      tbl.push_back(r(0, 4'b1011, 25, 0, 1, 1, 3, 1, 0, 1, 1));
      tbl.push_back(r(0, 4'b1011, 33, 0, 0, 0, 3, 0, 1, 1, 2));

      step();
      step();
      rst = 0;
      chk_row("reset", zero);
      chk("reset sat hit_cnt", s_hc, 0);

      run_rows("nominal", 0, 11);
      run_rows("miss", 12, 16);

      // abort with simultaneous start at cycle 12
      chart = 4'b0011; hit = 1; start = 1;
      step();
      start = 0; cyc = 1;
      while (cyc < 12) step();
      abort = 1; start = 1;
      step();
      abort = 0; start = 0;
      chk_row("abort", r(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      ticks = 0; plays = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         ticks += tick_out;
         plays += playing;
      end
      chk("abort later ticks", ticks, 0);
      chk("abort later playing", plays, 0);

      // start in PLAY is ignored, then reset at cycle 5 of beat 2
      chart = 4'b0001; hit = 0; start = 1;
      step();
      start = 0; cyc = 1;
      while (cyc < 5) step();
      start = 1;
      step();
      start = 0;
      while (cyc < 8) step();
      chk("ignored start c8 tick", tick_out, 0);
      chk("ignored start c8 idx", beat_idx, 0);
      step();
      chk("ignored start c9 tick", tick_out, 1);
      chk("ignored start c9 idx", beat_idx, 1);
      chk("ignored start c9 miss", miss_cnt, 1);
      while (cyc < 22) step();
      rst = 1;
      step();
      rst = 0;
      chk_row("midreset", zero);
      run_rows("after reset", 0, 11);

      // saturation: 300 note beats all hit
      s_start = 1;
      step();
      s_start = 0; cyc = 1;
      chk("sat c1 tick", s_tick, 1);
      while (cyc < 509) step();
      chk("sat c509 hit_cnt", s_hc, 254);
      step(); step();
      chk("sat c511 hit_cnt", s_hc, 255);
      while (cyc < 600) step();
      chk("sat c600 done", s_done, 0);
      step();
      chk("sat c601 done", s_done, 1);
      chk("sat c601 idx", s_idx, 299);
      chk("sat c601 hit_cnt", s_hc, 255);
      chk("sat c601 miss_cnt", s_mc, 0);
      for (int i = 0; i < 5; i++) step();
      chk("sat hold hit_cnt", s_hc, 255);
      chk("sat hold play", s_play, 0);
      chk("sat hold should_hit", s_sh, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Beat/note sequencer that drives the hit-detector side of the music game. Generates the per-beat `tick_out` pulse and the `should_hit` note window from a chart latched at start, then samples the detector's `hit` result at each beat end to tally hits and misses. Sits between the game control FSM (start/abort, chart select) and the hit detector / score display.

## Interface
- `TICK_DIV`, 1_000_000: clock cycles per beat; legal range 2 to 2^CNT_W.
- `CNT_W`, 20: width of the beat divider counter.
- `WINDOW`, 250_000: number of cycles at the start of each beat during which `should_hit` may be high; legal range 1 to TICK_DIV.
- `CHART_LEN`, 32: beats per song; legal range 2 to 2^IDX_W.
- `IDX_W`, 5: width of `beat_idx`.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; begins the song from beat 0. Honoured in IDLE or DONE, ignored in PLAY.
- `abort`  in  1  returns to IDLE; takes effect only in PLAY.
- `chart`  in  CHART_LEN  note map, bit i = note on beat i; sampled only on the accepted `start` edge.
- `hit`  in  1  latched hit flag from the hit detector; cleared by that detector on `tick_out`.
- `tick_out`  out  1  one-cycle pulse on the first cycle of every beat.
- `should_hit`  out  1  note window active.
- `beat_idx`  out  IDX_W  current beat number.
- `playing`  out  1  high in PLAY.
- `done`  out  1  high in DONE.
- `hit_cnt`  out  8  notes hit; saturates at 255.
- `miss_cnt`  out  8  notes missed; saturates at 255.

## Operation
- States: IDLE, PLAY, DONE. All outputs are registered or decoded from registers only. There is no combinational path from any input to any output.
- **Reset:** state = IDLE. `div_cnt`, `beat_idx`, `chart_q`, `hit_cnt` and `miss_cnt` are all 0. All outputs are 0.
- **IDLE or DONE with `start`:**
  - latch `chart` into `chart_q`;
  - clear `hit_cnt`, `miss_cnt`, `beat_idx` and `div_cnt`;
  - go to PLAY and set `tick_out` = 1 for the next cycle.
- **PLAY:**
  - `div_cnt` increments every cycle.
  - When `div_cnt` = TICK_DIV-1 (the last cycle of the beat):
    - Tally: if `chart_q[beat_idx]`, increment `hit_cnt` when `hit` = 1, otherwise increment `miss_cnt`. Beats with no note do not tally.
    - If `beat_idx` = CHART_LEN-1: go to DONE, with no further `tick_out`.
    - Otherwise: `div_cnt` becomes 0, `beat_idx` increments, and `tick_out` = 1 on the following cycle.
- `should_hit` = PLAY && `chart_q[beat_idx]` && (`div_cnt` < WINDOW).
- **DONE:** `done` holds at 1. `beat_idx` holds CHART_LEN-1. The counts hold. `tick_out` and `should_hit` are 0.
- **`abort` in PLAY:** go to IDLE on the next edge. The partial beat is not tallied. Counts and `beat_idx` hold their values. `tick_out` and `should_hit` drop.
- **Priority:** `rst` > `abort` > `start`. `abort` and `start` together in PLAY means abort. `abort` in IDLE or DONE is ignored, so `start` proceeds.
- **Counters:** each saturates at 255. Any increment attempted at 255 leaves the value at 255.

## Timing
- `start` sampled at edge k:
  - from cycle k+1: `playing` = 1, `tick_out` = 1, `beat_idx` = 0, `should_hit` = `chart[0]`.
- Each beat lasts exactly TICK_DIV cycles.
- `tick_out` pulses occur TICK_DIV cycles apart; there are exactly CHART_LEN pulses per song.
- `should_hit` is high on cycles 0 through WINDOW-1 of a note beat.
  - If WINDOW = TICK_DIV, `should_hit` stays continuously high across consecutive note beats.
- The tally uses `hit` as sampled on the beat's last cycle. The updated count is visible the next cycle, which is the same cycle as the following `tick_out` (or the first DONE cycle).
- `done` rises exactly CHART_LEN×TICK_DIV cycles after the first `tick_out`.
- `rst` mid-song forces the reset state at the next edge.

## Test plan
Bench parameters: TICK_DIV=8, WINDOW=3, CHART_LEN=4, IDX_W=2.

1. **Nominal song.** `chart`=4'b0101, `start` pulse, `hit` held 1.
   - `tick_out` pulses at cycles 1, 9, 17 and 25 after the `start` edge.
   - `should_hit` is high on cycles 1–3 and 17–19.
   - `done` = 1 at cycle 33.
   - `hit_cnt` = 2, `miss_cnt` = 0.
2. **Miss and empty beats.** `chart`=4'b1011, `hit` = 1 only during beat 1.
   - Result: `hit_cnt` = 1, `miss_cnt` = 2.
   - Beat 2 (no note) changes neither count.
3. **Abort.** Assert `abort` at cycle 12; also assert `start` at cycle 12.
   - Next cycle: IDLE, `playing` = 0, `beat_idx` = 1.
   - Counts reflect beat 0 only.
   - No `tick_out` afterwards.
4. **Restart and ignored start.**
   - `start` during PLAY: beat timing is unchanged.
   - `start` in DONE: counts cleared, `beat_idx` = 0, `tick_out` on the next cycle.
5. **Saturation.** CHART_LEN=300, IDX_W=9, all notes, `hit` = 1.
   - `hit_cnt` stops at 255 and holds through DONE.
6. **Reset mid-beat.** Assert `rst` at cycle 5 of beat 2.
   - All outputs are 0 on the next cycle.
   - A subsequent `start` behaves as in scenario 1.
